derived_clk_gen: RTL and testbench
==================================

// Module: derived_clk_gen
//
// PURPOSE
//   Synthesisable generator for the dependent clock "other_clk" consumed by the
//   DPI ordering testbench; replaces the DPI toggle path with RTL.
//   Divides clk by a programmable half-period, counts rising edges of the
//   derived clock, and stops after a programmable number of edges.
//   Sits directly upstream of the logic clocked by other_clk.
//
// PARAMETERS
//   DIV_W  8  width of div input (half-period in clk cycles)
//   CNT_W  8  width of edge_limit / edge_cnt
//
// PORTS
//   clk         in   1      primary clock, all state on posedge
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      level, sampled each posedge; begins a run from IDLE/DONE
//   stop        in   1      level; aborts a run, returns to IDLE
//   div         in   DIV_W  half-period d in clk cycles; 0 treated as 1
//   edge_limit  in   CNT_W  rising edges per run; 0 = free-run
//   other_clk   out  1      derived clock, registered
//   rise_pulse  out  1      high for the one clk cycle in which other_clk has just risen
//   edge_cnt    out  CNT_W  rising edges produced in current/last run
//   busy        out  1      state == RUN
//   done        out  1      state == DONE
//
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, other_clk=0, rise_pulse=0,
//     edge_cnt=0, phase=0, div_q=1, lim_q=0; busy=0, done=0.
//   States:
//     IDLE: other_clk=0, phase=0.
//       start & !stop -> RUN; latch div_q=max(div,1), lim_q=edge_limit;
//       edge_cnt=0.
//     RUN: each posedge:
//       - phase==div_q-1: toggle other_clk, phase=0.
//       - else: phase+1.
//       Rising toggle:
//       - edge_cnt+1 (wraps 2^CNT_W-1 -> 0 when lim_q==0); rise_pulse=1 next cycle.
//       - lim_q!=0 and new edge_cnt==lim_q: -> DONE on the same edge
//         (other_clk=1 in first DONE cycle).
//       stop -> IDLE next edge; other_clk=0, edge_cnt held.
//     DONE: other_clk forced 0 at first edge in DONE and held; edge_cnt held.
//       start & !stop -> RUN as from IDLE (edge_cnt cleared).
//       stop -> IDLE.
//   Timing: start seen at edge E0 -> RUN at E0, other_clk=0.
//     First rise at E0+d; k-th rise at E0+(2k-1)d; period 2d clk cycles,
//     50% duty.
//   div/edge_limit changes during RUN are ignored (latched values used).
//   start while RUN ignored; start and stop same edge: stop wins.
//   rise_pulse is never high outside the cycle following a rising toggle.
//   Reset mid-run: immediate return to reset values, other_clk drops
//     asynchronously.
//
// TESTING
//   1. Reset: rst_n=0 any time -> all outputs 0 within same cycle; no toggles
//      while rst_n=0.
//   2. div=1, edge_limit=21, start@E0 -> rises at E0+1,+3,...,+41.
//      edge_cnt=21, done=1 from E0+41, other_clk=0 from E0+42.
//   3. div=3, edge_limit=0, run 200 cycles -> period 6, 3-high/3-low.
//      rise_pulse count equals edge_cnt; wrap check with CNT_W=4
//      (15 -> 0).
//   4. div=0 -> behaves as div=1; change div to 5 mid-run -> period
//      unchanged at 2.
//   5. stop during RUN (other_clk=1) -> IDLE next edge, other_clk=0,
//      edge_cnt held. start+stop same edge from IDLE -> stays IDLE.
//   6. From DONE, start -> edge_cnt cleared, new run obeys new div/edge_limit;
//      rst_n pulse mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/derived_clk_gen.sv
// Derived clock generator: divides clk by a programmable half-period, counts
// rising edges of the derived clock and stops after a programmable edge count.
module derived_clk_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] edge_limit,
  output logic             other_clk,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_phase;
  logic [DIV_W-1:0] r_div_q;
  logic [CNT_W-1:0] r_lim_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_other_clk;
  logic             r_rise;

  logic [DIV_W-1:0] w_div_eff;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_div_eff = (div == '0) ? DIV_W'(1) : div;
  assign w_last    = (r_phase == r_div_q - DIV_W'(1));
  assign w_cnt_nxt = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_div_q     <= DIV_W'(1);
      r_lim_q     <= '0;
      r_cnt       <= '0;
      r_other_clk <= 1'b0;
      r_rise      <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_other_clk <= 1'b0;
          r_phase     <= '0;
          if (stop) begin
            r_state <= S_IDLE;
          end else if (start) begin
            r_state <= S_RUN;
            r_div_q <= w_div_eff;
            r_lim_q <= edge_limit;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state     <= S_IDLE;
            r_other_clk <= 1'b0;
            r_phase     <= '0;
          end else if (w_last) begin
            r_phase     <= '0;
            r_other_clk <= ~r_other_clk;
            // Rising toggle: count it and finish on the same edge at the limit.
            if (!r_other_clk) begin
              r_rise <= 1'b1;
              r_cnt  <= w_cnt_nxt;
              if (r_lim_q != '0 && w_cnt_nxt == r_lim_q) r_state <= S_DONE;
            end
          end else begin
            r_phase <= r_phase + DIV_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign other_clk  = r_other_clk;
  assign rise_pulse = r_rise;
  assign edge_cnt   = r_cnt;
  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_derived_clk_gen.sv
// Directed self-checking bench for derived_clk_gen (8-bit and 4-bit counter builds).
module tb_derived_clk_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [7:0] div;
  logic [7:0] edge_limit;
  logic       other_clk, rise_pulse, busy, done;
  logic [7:0] edge_cnt;
  logic       oc4, rp4, busy4, done4;
  logic [3:0] cnt4;

  int n_chk = 0;
  int n_bad = 0;
  int n_rise;

  derived_clk_gen #(.DIV_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .div(div),
    .edge_limit(edge_limit), .other_clk(other_clk), .rise_pulse(rise_pulse),
    .edge_cnt(edge_cnt), .busy(busy), .done(done)
  );

  derived_clk_gen #(.DIV_W(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .div(div[3:0]),
    .edge_limit(edge_limit[3:0]), .other_clk(oc4), .rise_pulse(rp4),
    .edge_cnt(cnt4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".oc"}, 32'(other_clk), 0);
    chk({tag, ".rp"}, 32'(rise_pulse), 0);
    chk({tag, ".cnt"}, 32'(edge_cnt), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".oc4"}, 32'(oc4), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; stop = 1'b0; div = 8'd1; edge_limit = 8'd0;
    #2;
    chk_zero("rst0");
    // Clock runs with start high while in reset: nothing may move.
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_oc", 32'(other_clk), 0);
      chk("rst_busy", 32'(busy), 0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk_zero("idle");

    // div=1, limit=21
    div = 8'd1; edge_limit = 8'd21; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_e0_busy", 32'(busy), 1);
    chk("t2_e0_oc", 32'(other_clk), 0);
    chk("t2_e0_cnt", 32'(edge_cnt), 0);
    for (int k = 1; k <= 42; k++) begin
      tick();
      chk("t2_oc", 32'(other_clk), (k <= 41) ? 32'(k % 2) : 0);
      chk("t2_cnt", 32'(edge_cnt), (k <= 41) ? 32'((k + 1) / 2) : 21);
      chk("t2_done", 32'(done), (k >= 41) ? 1 : 0);
      chk("t2_busy", 32'(busy), (k >= 41) ? 0 : 1);
      chk("t2_rp", 32'(rise_pulse), (k <= 41 && (k % 2) == 1) ? 1 : 0);
    end

    // div=3 free-run, 4-bit counter wraps 15 -> 0
    div = 8'd3; edge_limit = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_e0_cnt", 32'(edge_cnt), 0);
    chk("t3_e0_cnt4", 32'(cnt4), 0);
    n_rise = 0;
    for (int k = 1; k <= 201; k++) begin
      tick();
      if (rise_pulse) n_rise++;
      chk("t3_oc", 32'(other_clk), 32'((k / 3) % 2));
      chk("t3_rp", 32'(rise_pulse), ((k % 6) == 3) ? 1 : 0);
      chk("t3_cnt", 32'(edge_cnt), 32'((k + 3) / 6));
      chk("t3_cnt4", 32'(cnt4), 32'(((k + 3) / 6) % 16));
    end
    chk("t3_nrise", 32'(n_rise), 32'(edge_cnt));
    chk("t3_final_cnt", 32'(edge_cnt), 34);

    // stop while other_clk=1, then start+stop together from IDLE
    stop = 1'b1;
    tick();
    chk("t5_oc", 32'(other_clk), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_cnt", 32'(edge_cnt), 34);
    start = 1'b1;
    tick();
    chk("t5_ss_busy", 32'(busy), 0);
    chk("t5_ss_cnt", 32'(edge_cnt), 34);
    start = 1'b0; stop = 1'b0;

    // div=0 acts as 1; div change mid-run ignored
    div = 8'd0; edge_limit = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 2) div = 8'd5;
      chk("t4_oc", 32'(other_clk), 32'(k % 2));
      chk("t4_cnt", 32'(edge_cnt), 32'((k + 1) / 2));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // short run to DONE, then restart from DONE with new settings
    div = 8'd1; edge_limit = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    chk("t6a_done", 32'(done), 1);
    chk("t6a_oc", 32'(other_clk), 0);
    chk("t6a_cnt", 32'(edge_cnt), 2);
    div = 8'd2; edge_limit = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_e0_cnt", 32'(edge_cnt), 0);
    chk("t6_e0_busy", 32'(busy), 1);
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk("t6_oc", 32'(other_clk), (k <= 10) ? 32'((k / 2) % 2) : 0);
      chk("t6_done", 32'(done), (k >= 10) ? 1 : 0);
      chk("t6_cnt", 32'(edge_cnt), (k <= 10) ? 32'((k + 2) / 4) : 3);
    end

    // async reset mid-run while other_clk is high
    div = 8'd2; edge_limit = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t6r_oc_pre", 32'(other_clk), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("t6r");
    tick();
    rst_n = 1'b1;
    tick();
    chk_zero("t6r_post");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
